// File: rtl/apb_slave_regfile.sv
// APB slave register file: NREGS-1 read/write bytes plus a read-only transfer counter at NREGS-1.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES access-phase wait states per transfer.
module apb_slave_regfile #(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_psel,
    input  logic       i_penable,
    input  logic       i_pwrite,
    input  logic [7:0] i_paddr,
    input  logic [7:0] i_pwdata,
    output logic       o_pready,
    output logic       o_pslverr,
    output logic [7:0] o_prdata,
    output logic [7:0] o_ctrl
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WCNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef APB_SLAVE_WAIT_EN
    localparam logic [1:0] ST_WAIT  = 2'd1;
`endif
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs_q [NREGS-1];
    logic [DATA_W-1:0] xfer_cnt_q;

    logic              setup_c;
    logic              access_c;
    logic              setup_err_c;
    logic [DATA_W-1:0] setup_rdata_c;
    logic              capture_c;
    logic              done_c;
    logic              pready_d;
    logic              pslverr_d;
    logic [DATA_W-1:0] prdata_d;

`ifdef APB_SLAVE_WAIT_EN
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = |WCNT_W'(WAIT_CYCLES);
`endif

    assign setup_c  = i_psel & ~i_penable;
    assign access_c = i_psel & i_penable;
    assign o_ctrl   = regs_q[0];

    // Error and read data are resolved at the setup edge so the counter is sampled there.
    always_comb begin
        setup_err_c   = (i_paddr >= DATA_W'(NREGS)) ||
                        (i_pwrite && (i_paddr == DATA_W'(NREGS - 1)));
        setup_rdata_c = '0;
        if (!setup_err_c && !i_pwrite) begin
            if (i_paddr == DATA_W'(NREGS - 1)) begin
                setup_rdata_c = xfer_cnt_q;
            end
            for (int i = 0; i < int'(NREGS) - 1; i++) begin
                if (i_paddr == DATA_W'(i)) begin
                    setup_rdata_c = regs_q[i];
                end
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        done_c    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
`ifdef APB_SLAVE_WAIT_EN
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (setup_c) begin
                    capture_c = 1'b1;
`ifdef APB_SLAVE_WAIT_EN
                    if (WAIT_CYCLES != 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_W'(WAIT_CYCLES);
                    end else begin
                        state_d = ST_READY;
                    end
`else
                    state_d = ST_READY;
`endif
                end
            end
`ifdef APB_SLAVE_WAIT_EN
            ST_WAIT: begin
                if (!i_psel) begin
                    state_d = ST_IDLE;
                end else if (i_penable) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_d = ST_READY;
                    end
                end
            end
`endif
            ST_READY: begin
                if (!i_psel) begin
                    state_d = ST_IDLE;
                end else if (access_c) begin
                    state_d = ST_IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_READY) begin
            pready_d  = 1'b1;
            pslverr_d = capture_c ? setup_err_c : err_q;
            prdata_d  = capture_c ? setup_rdata_c : rdata_q;
        end
    end

    // State, capture and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
`ifdef APB_SLAVE_WAIT_EN
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            o_pready  <= pready_d;
            o_pslverr <= pslverr_d;
            o_prdata  <= prdata_d;
`ifdef APB_SLAVE_WAIT_EN
            wcnt_q    <= wcnt_d;
`endif
            if (capture_c) begin
                idx_q   <= i_paddr[IDX_W-1:0];
                write_q <= i_pwrite;
                wdata_q <= i_pwdata;
                err_q   <= setup_err_c;
                rdata_q <= setup_rdata_c;
            end
        end
    end

    // Register file and transfer counter commit only on an error-free completion.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NREGS) - 1; i++) begin
                regs_q[i] <= '0;
            end
            xfer_cnt_q <= '0;
        end else if (done_c && !err_q) begin
            xfer_cnt_q <= xfer_cnt_q + DATA_W'(1);
            if (write_q) begin
                for (int i = 0; i < int'(NREGS) - 1; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        regs_q[i] <= wdata_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile; expected wait states follow APB_SLAVE_WAIT_EN.
module tb_apb_slave_regfile;

    localparam int unsigned NREGS = 16;
`ifdef APB_SLAVE_WAIT_EN
    localparam int unsigned WAITS = 2;
`else
    localparam int unsigned WAITS = 0;
`endif

    typedef struct packed {
        logic [7:0] rd;
        logic       err;
        logic       chk_rd;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_psel;
    logic       i_penable;
    logic       i_pwrite;
    logic [7:0] i_paddr;
    logic [7:0] i_pwdata;
    logic       o_pready;
    logic       o_pslverr;
    logic [7:0] o_prdata;
    logic [7:0] o_ctrl;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [7:0] m_regs [NREGS];
    logic [7:0] m_cnt;

    apb_slave_regfile #(.NREGS(NREGS), .WAIT_CYCLES(2)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_psel    (i_psel),
        .i_penable (i_penable),
        .i_pwrite  (i_pwrite),
        .i_paddr   (i_paddr),
        .i_pwdata  (i_pwdata),
        .o_pready  (o_pready),
        .o_pslverr (o_pslverr),
        .o_prdata  (o_prdata),
        .o_ctrl    (o_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 8'h00;
        m_cnt = 8'h00;
    endtask

    // One complete transfer starting at a negedge; returns at the negedge after completion.
    task automatic xfer(input logic [7:0] addr, input logic wr, input logic [7:0] data);
        exp_t e;
        exp_t got_e;
        logic err;
        int   waits;
        err      = (32'(addr) >= NREGS) || (wr && (32'(addr) == NREGS - 1));
        e.err    = err;
        e.chk_rd = !wr;
        e.rd     = (err || wr) ? 8'h00 :
                   ((32'(addr) == NREGS - 1) ? m_cnt : m_regs[addr[3:0]]);
        sb.push_back(e);
        i_psel    = 1'b1;
        i_penable = 1'b0;
        i_pwrite  = wr;
        i_paddr   = addr;
        i_pwdata  = data;
        @(negedge i_clk);
        i_penable = 1'b1;
        i_pwrite  = !wr;
        i_paddr   = ~addr;
        i_pwdata  = ~data;
        waits = 0;
        while (!o_pready && waits < 64) begin
            @(negedge i_clk);
            waits++;
        end
        got_e = sb.pop_front();
        if (!o_pready) begin
            chk("pready_timeout", 32'(o_pready), 32'd1);
        end else begin
            chk("wait_states", 32'(waits), 32'(WAITS));
            chk("pslverr", 32'(o_pslverr), 32'(got_e.err));
            if (got_e.chk_rd) chk("prdata", 32'(o_prdata), 32'(got_e.rd));
            @(negedge i_clk);
            if (!err) begin
                if (wr) m_regs[addr[3:0]] = data;
                m_cnt = m_cnt + 8'd1;
            end
            chk("pready_after", 32'(o_pready), 32'd0);
            chk("pslverr_idle", 32'(o_pslverr), 32'd0);
            chk("prdata_idle", 32'(o_prdata), 32'd0);
            chk("ctrl", 32'(o_ctrl), 32'(m_regs[0]));
        end
        i_psel    = 1'b0;
        i_penable = 1'b0;
    endtask

    // Setup then drop psel in the first access cycle (WAIT when wait states are enabled).
    task automatic abort_write(input logic [7:0] addr, input logic [7:0] data);
        i_psel    = 1'b1;
        i_penable = 1'b0;
        i_pwrite  = 1'b1;
        i_paddr   = addr;
        i_pwdata  = data;
        @(negedge i_clk);
        i_psel    = 1'b0;
        i_penable = 1'b0;
        @(negedge i_clk);
        chk("abort_pready", 32'(o_pready), 32'd0);
        chk("abort_ctrl", 32'(o_ctrl), 32'(m_regs[0]));
    endtask

    initial begin
        i_reset   = 1'b1;
        i_psel    = 1'b0;
        i_penable = 1'b0;
        i_pwrite  = 1'b0;
        i_paddr   = 8'h00;
        i_pwdata  = 8'h00;
        model_reset();
        #1;
        chk("rst_pready", 32'(o_pready), 32'd0);
        chk("rst_pslverr", 32'(o_pslverr), 32'd0);
        chk("rst_prdata", 32'(o_prdata), 32'd0);
        chk("rst_ctrl", 32'(o_ctrl), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Basic write/read, ctrl update, counter readback.
        xfer(8'h00, 1'b1, 8'hA5);
        xfer(8'h03, 1'b1, 8'h5A);
        xfer(8'h03, 1'b0, 8'h00);
        xfer(8'h0F, 1'b0, 8'h00);
        // Error cases and address boundaries.
        xfer(8'h20, 1'b0, 8'h00);
        xfer(8'h0F, 1'b1, 8'h77);
        xfer(8'h10, 1'b0, 8'h00);
        xfer(8'hFF, 1'b1, 8'h33);
        xfer(8'h0E, 1'b1, 8'hC3);
        xfer(8'h0E, 1'b0, 8'h00);
        xfer(8'h0F, 1'b0, 8'h00);
        xfer(8'h03, 1'b0, 8'h00);
        // Master abort leaves register 1 untouched.
        abort_write(8'h01, 8'h11);
        xfer(8'h01, 1'b0, 8'h00);
        // Long back-to-back run wrapping the transfer counter.
        for (int n = 0; n < 256; n++) begin
            xfer(8'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        xfer(8'h0F, 1'b0, 8'h00);
        chk("cnt_model_wrapped", 32'(m_cnt < 8'd100), 32'd1);
        xfer(8'h0F, 1'b0, 8'h00);

        // Reset mid-write: everything clears asynchronously, nothing commits.
        xfer(8'h00, 1'b1, 8'h3C);
        i_psel    = 1'b1;
        i_penable = 1'b0;
        i_pwrite  = 1'b1;
        i_paddr   = 8'h02;
        i_pwdata  = 8'h99;
        @(negedge i_clk);
        i_penable = 1'b1;
        #2;
        i_reset = 1'b1;
        #1;
        chk("midrst_pready", 32'(o_pready), 32'd0);
        chk("midrst_pslverr", 32'(o_pslverr), 32'd0);
        chk("midrst_prdata", 32'(o_prdata), 32'd0);
        chk("midrst_ctrl", 32'(o_ctrl), 32'd0);
        @(negedge i_clk);
        i_psel    = 1'b0;
        i_penable = 1'b0;
        i_reset   = 1'b0;
        model_reset();
        @(negedge i_clk);
        xfer(8'h02, 1'b0, 8'h00);
        xfer(8'h0F, 1'b0, 8'h00);
        xfer(8'h00, 1'b0, 8'h00);

        repeat (2) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
